uart_rx_frontend: RTL and testbench
===================================

// Module: uart_rx_frontend
// PURPOSE
//  Serial receive front-end upstream of the uart_to_bus master.
//  Synchronises the raw RX line, deserialises 8N1 frames by mid-bit
//  sampling, and buffers received bytes in a show-ahead FIFO.
//  The bus master pops bytes with a rd_en strobe.
//  Also reports framing and overrun errors and exposes FSM state for debug.
// PARAMETERS
//  CLK_PER_BIT  5208  clk cycles per bit (50 MHz / 9600 baud); must be >= 4
//  N            8     data bits per frame
//  DEPTH        8     FIFO entries; power of two, >= 2
// PORTS
//  clk         in   1          system clock
//  reset       in   1          asynchronous, active-low reset
//  rx_in       in   1          raw serial line, idle high, asynchronous to clk
//  rx_en       in   1          receiver enable; low forces FSM to IDLE
//  rd_en       in   1          pop strobe from uart_to_bus; one byte per cycle high
//  data_out    out  N          FIFO head byte, valid while data_valid=1
//  data_valid  out  1          FIFO not empty
//  full        out  1          FIFO holds DEPTH bytes
//  count       out  log2(DEPTH)+1  FIFO occupancy
//  frame_err   out  1          1-cycle pulse: stop bit sampled low
//  overrun     out  1          1-cycle pulse: good byte dropped because FIFO full
//  rx_present  out  3          FSM state encoding, for debug
// BEHAVIOUR
//  Reset (reset=0, async): FSM=IDLE, counters=0, sync FFs=1, FIFO empty.
//   Outputs during reset: data_out=0, data_valid=0, full=0, count=0,
//   frame_err=0, overrun=0, rx_present=IDLE.
//  Input sync: rx_in passes through a 2-FF synchroniser (reset value 1).
//   All decisions below use the synchronised line rx_s.
//  FSM states: IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4.
//  Bit-timer rule: the timer counts 0..CLK_PER_BIT-1. A "bit tick" occurs
//   at terminal count; the timer then reloads to 0.
//  IDLE: when rx_en=1 and rx_s=0 -> START, timer=0.
//  START: wait CLK_PER_BIT/2 cycles (integer divide), then resample rx_s.
//   - rx_s=1 -> glitch; go to IDLE, no error flagged.
//   - rx_s=0 -> go to DATA; bit index=0; timer=0.
//  DATA: on each bit tick, shift rx_s in LSB first.
//   - After the N-th sample -> STOP.
//  STOP: on the bit tick, sample rx_s.
//   - rx_s=1 and FIFO not full -> push the byte; go to IDLE.
//   - rx_s=1 and FIFO full -> byte dropped; overrun pulses; go to IDLE.
//   - rx_s=0 -> byte discarded; frame_err pulses; go to WAIT_IDLE.
//  WAIT_IDLE: stay until rx_s=1 (break condition), then go to IDLE.
//  rx_en=0 in any state -> next state IDLE; the partial frame is abandoned.
//   FIFO contents and occupancy are unaffected.
//  Latency: data_valid rises on the clk edge after the stop-bit sample
//   edge. Total from the rx_in stop-bit midpoint: 2 sync cycles + 1 cycle.
//  FIFO (show-ahead): data_out always shows the head entry.
//   - rd_en while empty is ignored; no pointer change.
//   - Push and pop in the same cycle: both occur, count unchanged.
//     This applies even when full, so a push is not an overrun when
//     rd_en=1 in that same cycle.
//   - Pointers use log2(DEPTH) bits and wrap naturally.
//   - count ranges 0..DEPTH; full = (count==DEPTH).
//  frame_err and overrun are registered pulses, exactly 1 cycle wide.
//  data_out is registered and holds its value when the FIFO is empty.
// STRUCTURE
//  Shared package uart_pkg:
//   - rx state localparams (IDLE..WAIT_IDLE);
//   - default baud constant CLK_PER_BIT_9600 = 5208.
//   - The tx side (uart_tx_toplevel) uses the same package.
//  Sub-module sync_fifo #(N, DEPTH):
//   - ports: clk, reset, wr_en, wr_data, rd_en, rd_data, count, full, empty;
//   - reusable for the TX buffer.
//  This module keeps the synchroniser, bit timer, and RX FSM.
// TESTING  (run with CLK_PER_BIT=8, N=8, DEPTH=4)
//  1. Send 0xA5 as 8N1 -> after the stop bit, data_valid=1, data_out=0xA5,
//     count=1; rd_en pulse -> data_valid=0, count=0.
//  2. rx_in low for 3 cycles, then high (glitch) -> FSM returns to IDLE
//     from START; no push, no frame_err.
//  3. Send 0x3C with the stop bit held low -> frame_err pulses once;
//     count stays 0; FSM in WAIT_IDLE until the line goes high.
//  4. Send 5 bytes 0x01..0x05 with no reads -> full=1 after the 4th byte;
//     the 5th byte pulses overrun. Pop 4 -> data_out sequence 01,02,03,04.
//  5. FIFO full; rd_en held high while a 6th byte 0x66 completes
//     -> push and pop in the same cycle; count stays 4; no overrun;
//     0x66 appears last.
//  6. Assert reset low mid-DATA, with 2 bytes queued -> all outputs
//     immediately reset; after release, a clean frame 0x81 is received
//     correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX front-end and the TX top level.
//  - CLK_PER_BIT_9600 : default bit period in clk cycles (50 MHz / 9600 baud)
//  - rx_state_t       : receive FSM state encoding, also exported for debug
package uart_pkg;

    localparam int unsigned CLK_PER_BIT_9600 = 5208;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO, shared by the UART RX and TX buffers.
//  clk     : system clock
//  reset   : asynchronous, active-low reset
//  wr_en   : push wr_data (accepted when not full, or when popping in the same cycle)
//  wr_data : byte to push
//  rd_en   : pop the head entry (ignored while empty)
//  rd_data : registered head entry; holds its last value while empty
//  count   : occupancy, 0..DEPTH
//  full    : count == DEPTH
//  empty   : count == 0
module sync_fifo #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [N-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [N-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count_next;
    logic          do_push;
    logic          do_pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A pop frees a slot in the same cycle, so a push while full is still accepted.
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);

    always_comb begin
        count_next  = count;
        rd_ptr_next = rd_ptr;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CW'(1);
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            // Registered show-ahead head: the next head is either the byte being
            // written this cycle (it lands exactly at the new read pointer) or
            // an entry already in memory. Hold the old value when going empty.
            if (count_next != '0) begin
                if (do_push && (wr_ptr == rd_ptr_next)) begin
                    rd_data <= wr_data;
                end else begin
                    rd_data <= mem[rd_ptr_next];
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front-end: 2-FF input synchroniser, mid-bit sampling 8N1
// deserialiser and show-ahead receive FIFO feeding uart_to_bus.
//  clk        : system clock
//  reset      : asynchronous, active-low reset
//  rx_in      : raw serial line, idle high, asynchronous to clk
//  rx_en      : receiver enable; low abandons any frame in progress
//  rd_en      : pop strobe, one byte per cycle high
//  data_out   : FIFO head byte, valid while data_valid=1
//  data_valid : FIFO not empty
//  full       : FIFO holds DEPTH bytes
//  count      : FIFO occupancy
//  frame_err  : 1-cycle pulse, stop bit sampled low
//  overrun    : 1-cycle pulse, good byte dropped because FIFO full
//  rx_present : receive FSM state, for debug
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_9600,
    parameter int unsigned N           = 8,
    parameter int unsigned DEPTH       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_in,
    input  logic                     rx_en,
    input  logic                     rd_en,
    output logic [N-1:0]             data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_err,
    output logic                     overrun,
    output logic [2:0]               rx_present
);

    localparam int unsigned TW = $clog2(CLK_PER_BIT);
    localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [TW-1:0] T_FULL = TW'(CLK_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLK_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] B_LAST = BW'(N - 1);

    rx_state_t     state;
    rx_state_t     state_next;
    logic          sync_q1;
    logic          rx_s;
    logic [TW-1:0] timer;
    logic [BW-1:0] bit_idx;
    logic [N-1:0]  shreg;
    logic          tick;
    logic          stop_sample;
    logic          push_req;
    logic          fe_set;
    logic          ov_set;
    logic          fifo_empty;

    // Input synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync_q1 <= rx_in;
            rx_s    <= sync_q1;
        end
    end

    // START ends after half a bit so that every later tick lands mid-bit.
    assign tick = (timer == ((state == RX_START) ? T_HALF : T_FULL));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!rx_en) begin
            state_next = RX_IDLE;
        end else begin
            unique case (state)
                RX_IDLE:      if (!rx_s) state_next = RX_START;
                RX_START:     if (tick) state_next = rx_s ? RX_IDLE : RX_DATA;
                RX_DATA:      if (tick && (bit_idx == B_LAST)) state_next = RX_STOP;
                RX_STOP:      if (tick) state_next = rx_s ? RX_IDLE : RX_WAIT_IDLE;
                RX_WAIT_IDLE: if (rx_s) state_next = RX_IDLE;
                default:      state_next = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_present  = state;
        stop_sample = rx_en && (state == RX_STOP) && tick;
        push_req    = stop_sample && rx_s;
        fe_set      = stop_sample && !rx_s;
        ov_set      = push_req && full && !rd_en;
    end

    // Bit timer restarts on every state change and every tick; it is held
    // at zero while waiting for a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if ((state_next != state) || tick || (state == RX_IDLE) ||
                (state == RX_WAIT_IDLE)) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end

            if (state != RX_DATA) begin
                bit_idx <= '0;
            end else if (tick) begin
                bit_idx <= bit_idx + BW'(1);
            end

            if ((state == RX_DATA) && tick) begin
                shreg <= {rx_s, shreg[N-1:1]};
            end

            frame_err <= fe_set;
            overrun   <= ov_set;
        end
    end

    sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_req),
        .wr_data (shreg),
        .rd_en   (rd_en),
        .rd_data (data_out),
        .count   (count),
        .full    (full),
        .empty   (fifo_empty)
    );

    assign data_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_frontend.sv
module tb_uart_rx_frontend;

    localparam int unsigned CPB   = 8;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_in = 1'b1;
    logic       rx_en = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       full;
    logic [2:0] count;
    logic       frame_err;
    logic       overrun;
    logic [2:0] rx_present;

    uart_rx_frontend #(
        .CLK_PER_BIT (CPB),
        .N           (8),
        .DEPTH       (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .rx_en      (rx_en),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .full       (full),
        .count      (count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .rx_present (rx_present)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pulse counters: a pulse held longer than one cycle counts more than once.
    int fe_cnt = 0;
    int ov_cnt = 0;
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
    end

    // Reference model: byte queue with the FIFO capacity rules.
    logic [7:0] q[$];
    logic [7:0] last_head = 8'h00;
    int exp_fe = 0;
    int exp_ov = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void refresh_head();
        if (q.size() > 0) last_head = q[0];
    endfunction

    function automatic void model_pop();
        if (q.size() > 0) begin
            last_head = q.pop_front();
            refresh_head();
        end
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else exp_ov++;
        refresh_head();
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_valid"}, 32'(data_valid), 32'(q.size() > 0));
        chk({tag, "_data"},  32'(data_out),   32'(last_head));
        chk({tag, "_count"}, 32'(count),      32'(q.size()));
        chk({tag, "_full"},  32'(full),       32'(q.size() == DEPTH));
        chk({tag, "_fe"},    32'(fe_cnt),     32'(exp_fe));
        chk({tag, "_ov"},    32'(ov_cnt),     32'(exp_ov));
    endtask

    // Drives one 8N1 frame. With pop_same, rd_en is high for exactly the
    // cycle in which the stop bit is sampled. A low stop bit is left on the line.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_same);
        @(posedge clk); #1 rx_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx_in = b[i];
        end
        repeat (CPB) @(posedge clk);
        #1 rx_in = stop;
        if (pop_same) begin
            repeat (CPB - 2) @(posedge clk);
            #1 rd_en = 1'b1;
            @(posedge clk);
            #1 rd_en = 1'b0;
            @(posedge clk);
        end else begin
            repeat (CPB) @(posedge clk);
        end
        #1 if (stop) rx_in = 1'b1;
    endtask

    task automatic frame(input string tag, input logic [7:0] b, input logic stop,
                         input logic pop_same);
        send_frame(b, stop, pop_same);
        if (pop_same) model_pop();
        if (stop) model_push(b);
        else exp_fe++;
        repeat (2) @(posedge clk);
        #1 check_state(tag);
    endtask

    task automatic pop(input string tag);
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
        model_pop();
        check_state(tag);
    endtask

    task automatic release_break(input string tag);
        repeat (3) @(posedge clk);
        #1 chk({tag, "_wait_idle"}, 32'(rx_present), 32'd4);
        rx_in = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk({tag, "_idle"}, 32'(rx_present), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_data",  32'(data_out),   32'd0);
        chk("rst_count", 32'(count),      32'd0);
        chk("rst_full",  32'(full),       32'd0);
        chk("rst_fe",    32'(frame_err),  32'd0);
        chk("rst_ov",    32'(overrun),    32'd0);
        chk("rst_state", 32'(rx_present), 32'd0);
        @(negedge clk); reset = 1'b1;
        repeat (3) @(posedge clk);

        // 1: single byte, then pop
        frame("t1_rx", 8'hA5, 1'b1, 1'b0);
        chk("t1_byte", 32'(data_out), 32'hA5);
        pop("t1_pop");

        // 2: 3-cycle glitch returns from START without effect
        @(posedge clk); #1 rx_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx_in = 1'b1;
        chk("t2_start", 32'(rx_present), 32'd1);
        repeat (10) @(posedge clk);
        #1 chk("t2_idle", 32'(rx_present), 32'd0);
        check_state("t2");

        // 3: framing error, break held low
        frame("t3_fe", 8'h3C, 1'b0, 1'b0);
        release_break("t3");

        // 4: overflow on the 5th byte, then drain in order
        for (int i = 1; i <= 5; i++) frame("t4_rx", 8'(i), 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            chk("t4_head", 32'(data_out), 32'(i));
            pop("t4_pop");
        end
        pop("t4_pop_empty");

        // 5: push and pop in the same cycle while full
        for (int i = 0; i < 4; i++) frame("t5_fill", 8'(8'h11 + i), 1'b1, 1'b0);
        frame("t5_same", 8'h66, 1'b1, 1'b1);
        chk("t5_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) pop("t5_drain");
        chk("t5_last", 32'(data_out), 32'h66);

        // rx_en low mid-frame abandons it
        @(posedge clk); #1 rx_in = 1'b0;
        repeat (20) @(posedge clk);
        #1 chk("en_data", 32'(rx_present), 32'd2);
        rx_en = 1'b0;
        @(posedge clk);
        #1 chk("en_idle", 32'(rx_present), 32'd0);
        rx_in = 1'b1;
        repeat (80) @(posedge clk);
        #1 rx_en = 1'b1;
        check_state("en");

        // Randomised traffic
        for (int n = 0; n < 24; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r < 3) begin
                pop("rnd_pop");
            end else begin
                logic [7:0] b;
                logic       stop;
                b    = 8'($urandom);
                stop = ($urandom_range(0, 7) != 0);
                frame("rnd_rx", b, stop, 1'b0);
                if (!stop) release_break("rnd");
            end
        end

        // 6: reset mid-DATA with bytes queued
        while (q.size() > 0) pop("t6_clear");
        frame("t6_q1", 8'h5A, 1'b1, 1'b0);
        frame("t6_q2", 8'hC3, 1'b1, 1'b0);
        @(posedge clk); #1 rx_in = 1'b0;
        repeat (30) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("t6_valid", 32'(data_valid), 32'd0);
        chk("t6_data",  32'(data_out),   32'd0);
        chk("t6_count", 32'(count),      32'd0);
        chk("t6_full",  32'(full),       32'd0);
        chk("t6_fe",    32'(frame_err),  32'd0);
        chk("t6_ov",    32'(overrun),    32'd0);
        chk("t6_state", 32'(rx_present), 32'd0);
        q.delete();
        last_head = 8'h00;
        rx_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        repeat (3) @(posedge clk);
        frame("t6_rx", 8'h81, 1'b1, 1'b0);
        chk("t6_byte", 32'(data_out), 32'h81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
